// File: rtl/per_interco_pkg.sv
// Shared defaults for the peripheral interconnect and the ID FIFO count-width helper.
package per_interco_pkg;

  localparam int ID_WIDTH   = 17;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  // Width needed to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/per_id_fifo.sv
// In-order ID FIFO with fall-through head; pointers wrap at DEPTH, including non-power-of-2 depths.
// Zero-latency read of the head; a push while full is accepted only when a pop frees the slot in the same cycle.
module per_id_fifo
  import per_interco_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (count == CW'(DEPTH));
  assign empty_o = (count == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/per_resp_tracker.sv
// Forwards arbitrated requests to one peripheral, queues granted IDs, returns responses one-hot one cycle later.
// Requests stall only when OUTSTANDING IDs are in flight; responses are never stalled. PER_RESP_CHECK_EN adds per_err_o.
module per_resp_tracker
  import per_interco_pkg::*;
#(
  parameter int ID_WIDTH    = per_interco_pkg::ID_WIDTH,
  parameter int ADDR_WIDTH  = per_interco_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH  = per_interco_pkg::DATA_WIDTH,
  parameter int BE_WIDTH    = DATA_WIDTH / 8,
  parameter int OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_add_i,
  input  logic                  data_wen_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  input  logic [BE_WIDTH-1:0]   data_be_i,
  input  logic [ID_WIDTH-1:0]   data_ID_i,
  output logic                  data_gnt_o,
  output logic                  per_req_o,
  output logic [ADDR_WIDTH-1:0] per_add_o,
  output logic                  per_wen_o,
  output logic [DATA_WIDTH-1:0] per_wdata_o,
  output logic [BE_WIDTH-1:0]   per_be_o,
  input  logic                  per_gnt_i,
  input  logic                  per_r_valid_i,
  input  logic [DATA_WIDTH-1:0] per_r_rdata_i,
  input  logic                  per_r_opc_i,
  output logic [ID_WIDTH-1:0]   data_r_valid_o,
  output logic [DATA_WIDTH-1:0] data_r_rdata_o,
  output logic                  data_r_opc_o
`ifdef PER_RESP_CHECK_EN
  ,
  output logic                  per_err_o
`endif
);

  logic                full;
  logic                empty;
  logic                pop;
  logic                push;
  logic [ID_WIDTH-1:0] head_id;

  // A response arriving with nothing outstanding is dropped rather than popped.
  assign pop        = per_r_valid_i & ~empty;
  assign per_req_o  = data_req_i & (~full | pop);
  assign data_gnt_o = per_req_o & per_gnt_i;
  assign push       = data_gnt_o;

  assign per_add_o   = data_add_i;
  assign per_wen_o   = data_wen_i;
  assign per_wdata_o = data_wdata_i;
  assign per_be_o    = data_be_i;

  per_id_fifo #(
    .WIDTH (ID_WIDTH),
    .DEPTH (OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (data_ID_i),
    .pop_i   (pop),
    .data_o  (head_id),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r_valid_o <= '0;
      data_r_rdata_o <= '0;
      data_r_opc_o   <= 1'b0;
    end else begin
      data_r_valid_o <= pop ? head_id : '0;
      if (pop) begin
        data_r_rdata_o <= per_r_rdata_i;
        data_r_opc_o   <= per_r_opc_i;
      end
    end
  end

`ifdef PER_RESP_CHECK_EN
  logic unexp_resp;
  logic bad_id;

  assign unexp_resp = per_r_valid_i & empty;
  assign bad_id     = push & ~$onehot(data_ID_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_err_o <= 1'b0;
    end else begin
      per_err_o <= per_err_o | unexp_resp | bad_id;
      assert (!unexp_resp) else $error("per_resp_tracker: response with no outstanding request");
      assert (!bad_id) else $error("per_resp_tracker: granted ID is not one-hot");
    end
  end
`endif

endmodule

// File: tb/tb_per_resp_tracker.sv
// Directed bench for per_resp_tracker: grant gating, in-order ID return, full push/pop, stall, reset mid-flight.
module tb_per_resp_tracker;

  localparam int IDW = 17;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           data_req_i;
  logic [AW-1:0]  data_add_i;
  logic           data_wen_i;
  logic [DW-1:0]  data_wdata_i;
  logic [BW-1:0]  data_be_i;
  logic [IDW-1:0] data_ID_i;
  logic           data_gnt_o;
  logic           per_req_o;
  logic [AW-1:0]  per_add_o;
  logic           per_wen_o;
  logic [DW-1:0]  per_wdata_o;
  logic [BW-1:0]  per_be_o;
  logic           per_gnt_i;
  logic           per_r_valid_i;
  logic [DW-1:0]  per_r_rdata_i;
  logic           per_r_opc_i;
  logic [IDW-1:0] data_r_valid_o;
  logic [DW-1:0]  data_r_rdata_o;
  logic           data_r_opc_o;
`ifdef PER_RESP_CHECK_EN
  logic           per_err_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  per_resp_tracker #(
    .ID_WIDTH    (IDW),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .BE_WIDTH    (BW),
    .OUTSTANDING (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_req_i     (data_req_i),
    .data_add_i     (data_add_i),
    .data_wen_i     (data_wen_i),
    .data_wdata_i   (data_wdata_i),
    .data_be_i      (data_be_i),
    .data_ID_i      (data_ID_i),
    .data_gnt_o     (data_gnt_o),
    .per_req_o      (per_req_o),
    .per_add_o      (per_add_o),
    .per_wen_o      (per_wen_o),
    .per_wdata_o    (per_wdata_o),
    .per_be_o       (per_be_o),
    .per_gnt_i      (per_gnt_i),
    .per_r_valid_i  (per_r_valid_i),
    .per_r_rdata_i  (per_r_rdata_i),
    .per_r_opc_i    (per_r_opc_i),
    .data_r_valid_o (data_r_valid_o),
    .data_r_rdata_o (data_r_rdata_o),
    .data_r_opc_o   (data_r_opc_o)
`ifdef PER_RESP_CHECK_EN
    ,
    .per_err_o      (per_err_o)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; combinational checks land 2ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Push one ID with the peripheral granting immediately.
  task automatic push_id(input logic [IDW-1:0] id, input string tag);
    data_req_i = 1'b1;
    data_ID_i  = id;
    per_gnt_i  = 1'b1;
    settle();
    chk({tag, "_gnt"}, 64'(data_gnt_o), 64'd1);
    tick();
    data_req_i = 1'b0;
  endtask

  // Return one response and check the routed ID and data one cycle later.
  task automatic respond(input logic [DW-1:0] rd, input logic [IDW-1:0] exp_id, input string tag);
    per_r_valid_i = 1'b1;
    per_r_rdata_i = rd;
    tick();
    per_r_valid_i = 1'b0;
    chk({tag, "_vld"}, 64'(data_r_valid_o), 64'(exp_id));
    if (exp_id != '0) chk({tag, "_rdata"}, 64'(data_r_rdata_o), 64'(rd));
  endtask

  initial begin
    rst_n         = 1'b0;
    data_req_i    = 1'b0;
    data_add_i    = '0;
    data_wen_i    = 1'b0;
    data_wdata_i  = '0;
    data_be_i     = '0;
    data_ID_i     = '0;
    per_gnt_i     = 1'b0;
    per_r_valid_i = 1'b0;
    per_r_rdata_i = '0;
    per_r_opc_i   = 1'b0;

    #3;
    chk("rst_rvalid", 64'(data_r_valid_o), 64'd0);
    chk("rst_rdata",  64'(data_r_rdata_o), 64'd0);
    chk("rst_opc",    64'(data_r_opc_o),   64'd0);
    chk("rst_req",    64'(per_req_o),      64'd0);
`ifdef PER_RESP_CHECK_EN
    chk("rst_err",    64'(per_err_o),      64'd0);
`endif
    #9 rst_n = 1'b1;
    tick();

    // Single read with pass-through fields and a 3-cycle peripheral latency.
    data_req_i   = 1'b1;
    data_ID_i    = 17'h00004;
    data_add_i   = 32'h0000_0100;
    data_wen_i   = 1'b1;
    data_wdata_i = 32'h1234_5678;
    data_be_i    = 4'hA;
    per_gnt_i    = 1'b1;
    settle();
    chk("rd_req",   64'(per_req_o),   64'd1);
    chk("rd_gnt",   64'(data_gnt_o),  64'd1);
    chk("rd_add",   64'(per_add_o),   64'h100);
    chk("rd_wen",   64'(per_wen_o),   64'd1);
    chk("rd_wdata", 64'(per_wdata_o), 64'h1234_5678);
    chk("rd_be",    64'(per_be_o),    64'hA);
    tick();
    data_req_i = 1'b0;
    tick();
    tick();
    per_r_valid_i = 1'b1;
    per_r_rdata_i = 32'hDEADBEEF;
    per_r_opc_i   = 1'b1;
    settle();
    chk("rd_not_yet", 64'(data_r_valid_o), 64'd0);
    tick();
    per_r_valid_i = 1'b0;
    per_r_opc_i   = 1'b0;
    chk("rd_vld",   64'(data_r_valid_o), 64'h00004);
    chk("rd_rdata", 64'(data_r_rdata_o), 64'hDEADBEEF);
    chk("rd_opc",   64'(data_r_opc_o),   64'd1);
    tick();
    chk("rd_one_cycle", 64'(data_r_valid_o), 64'd0);
    chk("rd_hold",      64'(data_r_rdata_o), 64'hDEADBEEF);
    chk("opc_hold",     64'(data_r_opc_o),   64'd1);

    // Fill to four outstanding; the fifth request is held off.
    push_id(17'h00001, "fill0");
    push_id(17'h00002, "fill1");
    push_id(17'h00004, "fill2");
    push_id(17'h00008, "fill3");
    data_req_i = 1'b1;
    data_ID_i  = 17'h00010;
    settle();
    chk("full_req", 64'(per_req_o),  64'd0);
    chk("full_gnt", 64'(data_gnt_o), 64'd0);
    tick();
    data_req_i = 1'b0;
    respond(32'h11, 17'h00001, "drain0");
    respond(32'h22, 17'h00002, "drain1");
    respond(32'h33, 17'h00004, "drain2");
    respond(32'h44, 17'h00008, "drain3");

    // Full with simultaneous push and pop.
    push_id(17'h00040, "pf0");
    push_id(17'h00080, "pf1");
    push_id(17'h00100, "pf2");
    push_id(17'h00200, "pf3");
    data_req_i    = 1'b1;
    data_ID_i     = 17'h00020;
    per_r_valid_i = 1'b1;
    per_r_rdata_i = 32'hA0;
    settle();
    chk("pp_req", 64'(per_req_o),  64'd1);
    chk("pp_gnt", 64'(data_gnt_o), 64'd1);
    tick();
    per_r_valid_i = 1'b0;
    data_ID_i     = 17'h00400;
    chk("pp_head", 64'(data_r_valid_o), 64'h00040);
    settle();
    chk("pp_still_full", 64'(per_req_o), 64'd0);
    data_req_i = 1'b0;
    tick();
    respond(32'hA1, 17'h00080, "pp_d0");
    respond(32'hA2, 17'h00100, "pp_d1");
    respond(32'hA3, 17'h00200, "pp_d2");
    respond(32'hA4, 17'h00020, "pp_last");

    // Peripheral stall for five cycles, then a single grant.
    data_req_i = 1'b1;
    data_ID_i  = 17'h00008;
    per_gnt_i  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("stall_req", 64'(per_req_o),  64'd1);
      chk("stall_gnt", 64'(data_gnt_o), 64'd0);
      tick();
    end
    per_gnt_i = 1'b1;
    settle();
    chk("stall_release_gnt", 64'(data_gnt_o), 64'd1);
    tick();
    data_req_i = 1'b0;
    respond(32'h55, 17'h00008, "stall_resp");
    // Only one entry was pushed, so this response has nothing to pair with.
    respond(32'h66, 17'h00000, "unexp");
    chk("unexp_rdata_hold", 64'(data_r_rdata_o), 64'h55);
`ifdef PER_RESP_CHECK_EN
    chk("unexp_err", 64'(per_err_o), 64'd1);
    tick();
    chk("err_sticky", 64'(per_err_o), 64'd1);
`endif

    // count == 1 with simultaneous push and pop.
    push_id(17'h00002, "c1_push");
    data_req_i    = 1'b1;
    data_ID_i     = 17'h01000;
    per_r_valid_i = 1'b1;
    per_r_rdata_i = 32'h77;
    settle();
    chk("c1_gnt", 64'(data_gnt_o), 64'd1);
    tick();
    data_req_i    = 1'b0;
    per_r_valid_i = 1'b0;
    chk("c1_old_head", 64'(data_r_valid_o), 64'h00002);
    respond(32'h88, 17'h01000, "c1_new");
    respond(32'h99, 17'h00000, "c1_empty");

    // Reset mid-flight with two outstanding; one response is on the output.
    push_id(17'h00004, "rf0");
    push_id(17'h00008, "rf1");
    push_id(17'h00010, "rf2");
    respond(32'hCC, 17'h00004, "rf_pre");
    settle();
    rst_n = 1'b0;
    #1;
    chk("rf_async_vld",   64'(data_r_valid_o), 64'd0);
    chk("rf_async_rdata", 64'(data_r_rdata_o), 64'd0);
    #1 rst_n = 1'b1;
    tick();
    respond(32'hDD, 17'h00000, "rf_late");
    push_id(17'h00001, "rf_new");
    respond(32'hEE, 17'h00001, "rf_new_resp");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
